// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: operation codes, FSM states and
// the stage-selection helper used when stage skipping (SHIFT_SEQ_SKIP_EN) is built in.
package shift_seq_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S8   = 3'd1,
        S4   = 3'd2,
        S2   = 3'd3,
        S1   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Highest stage whose count bit is still set, or DONE when none remain.
    function automatic state_t first_stage(input logic [3:0] bits);
        if (bits[3])      return S8;
        else if (bits[2]) return S4;
        else if (bits[1]) return S2;
        else if (bits[0]) return S1;
        else              return DONE;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One fixed-distance stage of the sequential barrel shifter; passes data
// through unchanged when not enabled.
module shift_stage
    import shift_seq_pkg::*;
#(
    parameter int unsigned amount = 1
) (
    input  logic [DATA_W-1:0] data,
    input  op_t               Op,
    input  logic              enable,
    output logic [DATA_W-1:0] result
);

    // NOTE: every path assigns result first, so no latch is inferred.
    always_comb begin
        result = data;
        if (enable) begin
            case (Op)
                OP_SLL:  result = data << amount;
                OP_SRL:  result = data >> amount;
                // Each stage re-extends the current bit 15, which an arithmetic
                // shift never changes, so the captured sign propagates.
                OP_SRA:  result = DATA_W'($signed(data) >>> amount);
                OP_ROL:  result = (data << amount) | (data >> (DATA_W - amount));
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: operand walks through stages 8/4/2/1, one per cycle.
// Define SHIFT_SEQ_SKIP_EN to skip stages whose count bit is zero.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] In,
    input  logic [3:0]        Cnt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Out
);

    state_t            state_q, state_d, entry_state;
    logic [DATA_W-1:0] data_q;
    op_t               op_q;
    logic [3:0]        cnt_q;
    logic              accept;
    logic [DATA_W-1:0] s8_out, s4_out, s2_out, s1_out;

    assign accept = start && (state_q == IDLE || state_q == DONE);

`ifdef SHIFT_SEQ_SKIP_EN
    assign entry_state = first_stage(Cnt);
`else
    assign entry_state = S8;
`endif

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: state_d = accept ? entry_state : IDLE;
            DONE: begin
                done    = 1'b1;
                state_d = accept ? entry_state : IDLE;
            end
`ifdef SHIFT_SEQ_SKIP_EN
            S8: begin busy = 1'b1; state_d = first_stage({1'b0, cnt_q[2:0]}); end
            S4: begin busy = 1'b1; state_d = first_stage({2'b0, cnt_q[1:0]}); end
            S2: begin busy = 1'b1; state_d = first_stage({3'b0, cnt_q[0]});   end
`else
            S8: begin busy = 1'b1; state_d = S4; end
            S4: begin busy = 1'b1; state_d = S2; end
            S2: begin busy = 1'b1; state_d = S1; end
`endif
            S1: begin busy = 1'b1; state_d = DONE; end
            default: state_d = IDLE;
        endcase
    end

    // Stages are chained, but only the one matching the current state is enabled,
    // so s1_out is the data register after this cycle's single stage.
    shift_stage #(.amount(8)) u_stage8 (
        .data(data_q), .Op(op_q), .enable(state_q == S8 && cnt_q[3]), .result(s8_out));
    shift_stage #(.amount(4)) u_stage4 (
        .data(s8_out), .Op(op_q), .enable(state_q == S4 && cnt_q[2]), .result(s4_out));
    shift_stage #(.amount(2)) u_stage2 (
        .data(s4_out), .Op(op_q), .enable(state_q == S2 && cnt_q[1]), .result(s2_out));
    shift_stage #(.amount(1)) u_stage1 (
        .data(s2_out), .Op(op_q), .enable(state_q == S1 && cnt_q[0]), .result(s1_out));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= OP_SLL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= In;
                op_q   <= op_t'(Op);
                cnt_q  <= Cnt;
            end else if (busy) begin
                data_q <= s1_out;
            end
        end
    end

    assign Out = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a whole-shift
// arithmetic model; follows SHIFT_SEQ_SKIP_EN for the expected latency.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  Op;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic        busy;
    logic        done;
    logic [15:0] Out;

    int n_pass  = 0;
    int n_total = 0;

    shift_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .Op(Op), .In(In), .Cnt(Cnt),
        .busy(busy), .done(done), .Out(Out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_out(input logic [1:0] op, input logic [15:0] a, input int n);
        logic [15:0] r;
        case (op)
            2'b00:   r = a << n;
            2'b01:   r = a >> n;
            2'b10:   r = 16'($signed(a) >>> n);
            default: r = (a << n) | (a >> (16 - n));
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [3:0] n);
`ifdef SHIFT_SEQ_SKIP_EN
        int ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(n[i]);
        return 1 + ones;
`else
        return 5;
`endif
    endfunction

    // Runs from the cycle after acceptance; optionally re-pulses start with a
    // different operand during cycle inj_cyc.
    task automatic wait_done(input int lat, input logic [15:0] exp, input string name,
                             input int inj_cyc, input logic [15:0] inj_in);
        int done_cyc = 0;
        int busy_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) done_cyc = c;
            if (inj_cyc != 0 && c == inj_cyc - 1) begin start = 1'b1; In = inj_in; end
            if (inj_cyc != 0 && c == inj_cyc) start = 1'b0;
        end
        if (inj_cyc != 0) start = 1'b0;
        n_total++;
        if (done_cyc !== lat) $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, lat);
        else n_pass++;
        n_total++;
        if (busy_cyc !== lat - 1) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, lat - 1);
        else n_pass++;
        n_total++;
        if (Out !== exp) $display("FAIL %s Out: got %h want %h", name, Out, exp);
        else n_pass++;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [3:0] n,
                         input string name, input int inj_cyc = 0, input logic [15:0] inj_in = 16'h0);
        start = 1'b1; Op = op; In = a; Cnt = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        Op  = 2'($urandom);
        In  = 16'($urandom);
        Cnt = 4'($urandom);
        wait_done(model_lat(n), model_out(op, a, int'(n)), name, inj_cyc, inj_in);
    endtask

    task automatic idle_tail(input logic [15:0] exp, input string name);
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0 || Out !== exp)
            $display("FAIL %s idle: got done=%b busy=%b Out=%h want 0 0 %h", name, done, busy, Out, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; Op = 2'b00; In = 16'h0; Cnt = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000)
            $display("FAIL reset: got busy=%b done=%b Out=%h want 0 0 0000", busy, done, Out);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(2'b00, 16'h00FF, 4'd4, "sll_00ff_4");
        idle_tail(16'h0FF0, "sll_00ff_4");
        do_op(2'b10, 16'h8000, 4'd15, "sra_8000_15");
        idle_tail(16'hFFFF, "sra_8000_15");
        do_op(2'b01, 16'h8000, 4'd15, "srl_8000_15");
        do_op(2'b11, 16'h8001, 4'd1, "rol_8001_1");
        do_op(2'b11, 16'hABCD, 4'd8, "rol_abcd_8");
        do_op(2'b01, 16'hBEEF, 4'd0, "cnt_zero");
        idle_tail(16'hBEEF, "cnt_zero");
    endtask

    task automatic test_ignore_start();
`ifdef SHIFT_SEQ_SKIP_EN
        do_op(2'b01, 16'hABCD, 4'hF, "ignore_start", 2, 16'h1234);
`else
        do_op(2'b01, 16'hABCD, 4'd8, "ignore_start", 2, 16'h1234);
`endif
        // Second request issued in the done cycle.
        do_op(2'b00, 16'h0001, 4'b0011, "back_to_back");
        idle_tail(16'h0008, "back_to_back");
    endtask

    task automatic test_abort();
        int stray = 0;
        start = 1'b1; Op = 2'b00; In = 16'h00FF; Cnt = 4'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL abort_running busy: got %b want 1", busy);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000)
            $display("FAIL abort_cleared: got busy=%b done=%b Out=%h want 0 0 0000", busy, done, Out);
        else n_pass++;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        n_total++;
        if (stray !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", stray);
        else n_pass++;

        do_op(2'b00, 16'h0001, 4'd1, "pre_priority");
        rst = 1'b1; start = 1'b1; In = 16'hFFFF; Cnt = 4'hF;
        @(posedge clk);
        #1 begin rst = 1'b0; start = 1'b0; end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000)
            $display("FAIL rst_priority: got busy=%b done=%b Out=%h want 0 0 0000", busy, done, Out);
        else n_pass++;
    endtask

    task automatic test_skip();
`ifdef SHIFT_SEQ_SKIP_EN
        do_op(2'b00, 16'h0001, 4'b0101, "skip_0101");
        idle_tail(16'h0020, "skip_0101");
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op = 2'($urandom);
            logic [15:0] a  = 16'($urandom);
            logic [3:0]  n  = 4'($urandom);
            int          gap = $urandom_range(0, 2);
            do_op(op, a, n, $sformatf("rand%0d", i));
            if (gap == 1) idle_tail(model_out(op, a, int'(n)), $sformatf("rand%0d", i));
            else if (gap == 2) repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_skip();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a shift; sampled only when accepting.
REQ-004 SHALL have port Op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-005 SHALL have port In  input  16  operand, captured on accepted start.
REQ-006 SHALL have port Cnt  input  4  shift amount 0..15, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while a stage cycle is executing.
REQ-008 SHALL have port done  output  1  single-cycle pulse: result valid.
REQ-009 SHALL have port Out  output  16  registered result, held until next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, S8, S4, S2, S1, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; accept = capture In into data register, Op and Cnt into control registers.
REQ-012 SHALL ignore start while busy; captured operands unaffected.
REQ-013 Accepted start SHALL transition IDLE/DONE -> S8; then S8->S4->S2->S1->DONE, one state per cycle.
REQ-014 In stage Sk the data register SHALL be shifted by k when the matching captured Cnt bit is 1, else pass unchanged.
REQ-015 SLL/SRL SHALL fill vacated bits with 0; SRA SHALL fill with captured bit 15; ROL SHALL wrap high bits into low bits.
REQ-016 Latency: start accepted in cycle 0 -> busy high cycles 1-4 -> done high and Out valid in cycle 5.
REQ-017 DONE without start SHALL go to IDLE next cycle; done deasserts; Out holds.
REQ-018 start in DONE SHALL be accepted (back-to-back); done high that cycle, busy high next cycle.
REQ-019 Out SHALL equal the data register; Out changes only at accept and stage edges; intermediate values not flagged valid.
REQ-020 Cnt=0 SHALL yield Out=In with full nominal latency (unless REQ-025).

Reset
REQ-021 rst SHALL force state IDLE, busy=0, done=0, Out=16'h0000 on the next rising edge.
REQ-022 rst mid-operation SHALL abort the shift; no done pulse for the aborted request.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro SHIFT_SEQ_SKIP_EN SHALL select stage skipping.
REQ-025 With SHIFT_SEQ_SKIP_EN defined: stages whose Cnt bit is 0 SHALL be skipped; busy cycles = popcount(Cnt); Cnt=0 goes straight to DONE in cycle 1.
REQ-026 Without SHIFT_SEQ_SKIP_EN: fixed 4 stage cycles per REQ-016.

Structure
REQ-027 Shared package shift_seq_pkg SHALL hold Op encodings and FSM state encodings.
REQ-028 Stage datapath SHALL be one sub-module shift_stage (16-bit, parameter amount, inputs data/Op/enable), instanced four times (8,4,2,1).
REQ-029 FSM and registers SHALL live in shift_sequencer; no other sub-modules.

Verification
REQ-030 SLL In=0x00FF Cnt=4 start cycle 0 -> busy cycles 1-4, done cycle 5, Out=0x0FF0.
REQ-031 SRA In=0x8000 Cnt=15 -> Out=0xFFFF; SRL same operands -> Out=0x0001.
REQ-032 ROL In=0x8001 Cnt=1 -> Out=0x0003; ROL In=0xABCD Cnt=8 -> Out=0xCDAB.
REQ-033 SRL In=0xABCD Cnt=8, start re-pulsed cycle 2 with In=0x1234 -> ignored, Out=0x00AB cycle 5; second start in cycle 5 accepted.
REQ-034 rst asserted cycle 2 of SLL -> cycle 3: busy=0, done=0, Out=0x0000, state IDLE; no done thereafter.
REQ-035 With SHIFT_SEQ_SKIP_EN: Cnt=0 -> done cycle 1 Out=In; SLL In=0x0001 Cnt=0b0101 -> busy cycles 1-2, done cycle 3, Out=0x0020.
